// File: rtl/ring_phase_monitor.sv
// Watches a one-hot ring counter: encodes the active bit, checks each step for legal
// rotate-left order, locks after a run of legal steps, counts revolutions, latches faults.
module ring_phase_monitor #(
    parameter int WIDTH      = 4,
    parameter int LOCK_STEPS = 4,
    parameter int REV_W      = 8,
    localparam int IDXW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             clear_i,
    output logic [IDXW-1:0]  idx_o,
    output logic             onehot_ok_o,
    output logic             locked_o,
    output logic             fault_o,
    output logic             wrap_o,
    output logic [REV_W-1:0] rev_cnt_o,
    output logic [1:0]       err_code_o
);

    localparam int SW = $clog2(LOCK_STEPS + 1);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [SW-1:0]    r_step;
    logic [IDXW-1:0]  r_idx;
    logic             r_ok;
    logic             r_locked;
    logic             r_fault;
    logic             r_wrap;
    logic [REV_W-1:0] r_rev;
    logic [1:0]       r_err;

    logic             w_onehot;
    logic             w_legal;
    logic             w_wrap_step;
    logic [WIDTH-1:0] w_rot;
    logic [IDXW-1:0]  w_idx;
    logic [SW-1:0]    w_step_inc;

    // Clearing the lowest set bit leaves zero only for a single-bit word.
    assign w_onehot    = (q_i != '0) && ((q_i & (q_i - 1'b1)) == '0);
    assign w_rot       = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
    assign w_legal     = w_onehot && (q_i == w_rot);
    assign w_wrap_step = r_prev[WIDTH-1] && q_i[0];
    assign w_step_inc  = r_step + 1'b1;

    always_comb begin
        w_idx = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (q_i[j]) begin
                w_idx = IDXW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= SYNC;
            r_prev   <= '0;
            r_step   <= '0;
            r_idx    <= '0;
            r_ok     <= 1'b0;
            r_locked <= 1'b0;
            r_fault  <= 1'b0;
            r_wrap   <= 1'b0;
            r_rev    <= '0;
            r_err    <= 2'b00;
        end else begin
            r_wrap <= 1'b0;
            if (clear_i) begin
                r_state  <= SYNC;
                r_prev   <= '0;
                r_step   <= '0;
                r_locked <= 1'b0;
                r_fault  <= 1'b0;
                r_rev    <= '0;
                r_err    <= 2'b00;
            end else if (valid_i) begin
                if (w_onehot) begin
                    r_idx  <= w_idx;
                    r_ok   <= 1'b1;
                    r_prev <= q_i;
                end else begin
                    r_ok <= 1'b0;
                end
                case (r_state)
                    SYNC: begin
                        if (w_onehot) begin
                            r_state <= TRACK;
                            r_step  <= '0;
                        end
                    end
                    TRACK: begin
                        if (!w_onehot) begin
                            r_state <= SYNC;
                        end else if (w_legal) begin
                            if (w_step_inc == SW'(LOCK_STEPS)) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                                r_step   <= '0;
                            end else begin
                                r_step <= w_step_inc;
                            end
                        end else begin
                            r_step <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!w_onehot) begin
                            r_state  <= FAULT;
                            r_locked <= 1'b0;
                            r_fault  <= 1'b1;
                            r_err    <= 2'b01;
                        end else if (!w_legal) begin
                            r_state  <= FAULT;
                            r_locked <= 1'b0;
                            r_fault  <= 1'b1;
                            r_err    <= 2'b10;
                        end else if (w_wrap_step) begin
                            r_wrap <= 1'b1;
                            r_rev  <= r_rev + REV_W'(1);
                        end
                    end
                    default: begin
                        // FAULT is sticky until clear or reset.
                    end
                endcase
            end
        end
    end

    assign idx_o       = r_idx;
    assign onehot_ok_o = r_ok;
    assign locked_o    = r_locked;
    assign fault_o     = r_fault;
    assign wrap_o      = r_wrap;
    assign rev_cnt_o   = r_rev;
    assign err_code_o  = r_err;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Bench for ring_phase_monitor: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a behavioural model (two REV_W variants).
module tb_ring_phase_monitor;

    localparam int W  = 4;
    localparam int LS = 4;

    logic       clk = 1'b0;
    logic       reset, valid_i, clear_i;
    logic [3:0] q_i;
    logic [1:0] idx_o, idx2_o;
    logic       onehot_ok_o, locked_o, fault_o, wrap_o;
    logic       onehot_ok2_o, locked2_o, fault2_o, wrap2_o;
    logic [7:0] rev_cnt_o;
    logic [1:0] rev_cnt2_o;
    logic [1:0] err_code_o, err_code2_o;

    always #5 clk = ~clk;

    ring_phase_monitor #(.WIDTH(W), .LOCK_STEPS(LS), .REV_W(8)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .q_i(q_i), .clear_i(clear_i),
        .idx_o(idx_o), .onehot_ok_o(onehot_ok_o), .locked_o(locked_o), .fault_o(fault_o),
        .wrap_o(wrap_o), .rev_cnt_o(rev_cnt_o), .err_code_o(err_code_o)
    );

    ring_phase_monitor #(.WIDTH(W), .LOCK_STEPS(LS), .REV_W(2)) dut2 (
        .clk(clk), .reset(reset), .valid_i(valid_i), .q_i(q_i), .clear_i(clear_i),
        .idx_o(idx2_o), .onehot_ok_o(onehot_ok2_o), .locked_o(locked2_o), .fault_o(fault2_o),
        .wrap_o(wrap2_o), .rev_cnt_o(rev_cnt2_o), .err_code_o(err_code2_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Behavioural model: mode 0 sync, 1 track, 2 locked, 3 fault; phase held as an index.
    int m_mode, m_streak, m_prev, m_rev, m_err, m_idx, m_ok, m_wrap;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic c, input logic v, input logic [3:0] q);
        bit oh, legal, wrapev;
        int k;
        if (r) begin
            m_mode = 0; m_streak = 0; m_prev = -1; m_rev = 0; m_err = 0;
            m_idx = 0; m_ok = 0; m_wrap = 0;
            return;
        end
        m_wrap = 0;
        if (c) begin
            m_mode = 0; m_streak = 0; m_rev = 0; m_err = 0; m_prev = -1;
            return;
        end
        if (!v) return;
        oh = ($countones(q) == 1);
        k = 0;
        for (int i = 0; i < W; i++) if (q[i]) k = i;
        legal  = oh && (m_prev >= 0) && (k == (m_prev + 1) % W);
        wrapev = legal && (m_prev == W - 1);
        case (m_mode)
            0: if (oh) begin m_mode = 1; m_streak = 0; end
            1: begin
                if (!oh) m_mode = 0;
                else if (legal) begin
                    m_streak++;
                    if (m_streak == LS) m_mode = 2;
                end else m_streak = 0;
            end
            2: begin
                if (!oh) begin m_mode = 3; m_err = 1; end
                else if (!legal) begin m_mode = 3; m_err = 2; end
                else if (wrapev) begin m_wrap = 1; m_rev = (m_rev + 1) % 256; end
            end
            default: ;
        endcase
        if (oh) begin m_idx = k; m_ok = 1; m_prev = k; end
        else m_ok = 0;
    endtask

    // One clock transaction: drive, clock, update model, check both instances.
    task automatic cycle(input logic r, input logic c, input logic v, input logic [3:0] q);
        reset = r; clear_i = c; valid_i = v; q_i = q;
        @(posedge clk);
        model_step(r, c, v, q);
        #1;
        cyc++;
        $display("cyc %0d rst=%b clr=%b vld=%b q=%b -> idx=%0d ok=%b lk=%b ft=%b wr=%b rev=%0d err=%0d",
                 cyc, r, c, v, q, idx_o, onehot_ok_o, locked_o, fault_o, wrap_o, rev_cnt_o, err_code_o);
        chk("idx",    int'(idx_o),       m_idx);
        chk("ok",     int'(onehot_ok_o), m_ok);
        chk("locked", int'(locked_o),    int'(m_mode == 2));
        chk("fault",  int'(fault_o),     int'(m_mode == 3));
        chk("wrap",   int'(wrap_o),      m_wrap);
        chk("rev",    int'(rev_cnt_o),   m_rev);
        chk("err",    int'(err_code_o),  m_err);
        chk("rev2",   int'(rev_cnt2_o),  m_rev % 4);
        chk("wrap2",  int'(wrap2_o),     m_wrap);
        chk("lock2",  int'(locked2_o),   int'(m_mode == 2));
        chk("both",   int'(locked_o & fault_o), 0);
    endtask

    typedef struct {
        logic       r, c, v;
        logic [3:0] q;
        int         idx, ok, lk, ft, wr, rev, err;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic c, input logic v, input logic [3:0] q,
                                input int idx, input int ok, input int lk, input int ft,
                                input int wr, input int rev, input int err);
        vec_t t;
        t.r = r; t.c = c; t.v = v; t.q = q;
        t.idx = idx; t.ok = ok; t.lk = lk; t.ft = ft; t.wr = wr; t.rev = rev; t.err = err;
        return t;
    endfunction

    vec_t tbl[23];

    initial begin
        int lock_ord, wraps, phase, sel;
        int wrap_ord[$];
        logic [3:0] qq;
        logic r, c, v;

        //            r  c  v  q        idx ok lk ft wr rev err
        tbl[0]  = mk(1, 0, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 4'b0001, 0, 1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 4'b0010, 1, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 4'b0100, 2, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 4'b1000, 3, 1, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 1, 4'b0001, 0, 1, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 4'b0010, 1, 1, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 4'b0100, 2, 1, 1, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 1, 4'b1000, 3, 1, 1, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, 4'b0001, 0, 1, 1, 0, 1, 1, 0);
        tbl[12] = mk(0, 0, 0, 4'b0101, 0, 1, 1, 0, 0, 1, 0);
        tbl[13] = mk(0, 0, 1, 4'b0101, 0, 0, 0, 1, 0, 1, 1);
        tbl[14] = mk(0, 0, 1, 4'b0010, 1, 1, 0, 1, 0, 1, 1);
        tbl[15] = mk(0, 1, 1, 4'b0100, 1, 1, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 1, 4'b0100, 2, 1, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 1, 4'b1000, 3, 1, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 0, 1, 4'b0001, 0, 1, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 1, 4'b0010, 1, 1, 0, 0, 0, 0, 0);
        tbl[20] = mk(0, 0, 1, 4'b0100, 2, 1, 1, 0, 0, 0, 0);
        tbl[21] = mk(0, 0, 1, 4'b0001, 0, 1, 0, 1, 0, 0, 2);
        tbl[22] = mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b1; clear_i = 1'b0; valid_i = 1'b0; q_i = '0;
        model_step(1'b1, 1'b0, 1'b0, 4'b0);

        for (int i = 0; i < 23; i++) begin
            cycle(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].q);
            chk("t_idx", int'(idx_o),       tbl[i].idx);
            chk("t_ok",  int'(onehot_ok_o), tbl[i].ok);
            chk("t_lk",  int'(locked_o),    tbl[i].lk);
            chk("t_ft",  int'(fault_o),     tbl[i].ft);
            chk("t_wr",  int'(wrap_o),      tbl[i].wr);
            chk("t_rev", int'(rev_cnt_o),   tbl[i].rev);
            chk("t_err", int'(err_code_o),  tbl[i].err);
        end

        // Gapped valid: lock and wraps land on the same sample ordinals as a continuous stream.
        cycle(1'b1, 1'b0, 1'b0, 4'b0);
        lock_ord = 0; wraps = 0;
        for (int s = 1; s <= 17; s++) begin
            qq = 4'b0001 << ((s - 1) % 4);
            cycle(1'b0, 1'b0, 1'b1, qq);
            if (locked_o && lock_ord == 0) lock_ord = s;
            if (wrap_o) wrap_ord.push_back(s);
            cycle(1'b0, 1'b0, 1'b0, 4'b1111);
            if (wrap_o) wraps++;
        end
        chk("gap_lock_ord", lock_ord, 5);
        chk("gap_wrap_cnt", wrap_ord.size(), 3);
        if (wrap_ord.size() == 3) begin
            chk("gap_wrap1", wrap_ord[0], 9);
            chk("gap_wrap2", wrap_ord[1], 13);
            chk("gap_wrap3", wrap_ord[2], 17);
        end
        chk("gap_spurious", wraps, 0);
        chk("gap_rev", int'(rev_cnt_o), 3);

        // Repeated sample in TRACK restarts the streak; lock moves from 5th to 7th sample.
        cycle(1'b1, 1'b0, 1'b0, 4'b0);
        cycle(1'b0, 1'b0, 1'b1, 4'b0001);
        cycle(1'b0, 1'b0, 1'b1, 4'b0010);
        cycle(1'b0, 1'b0, 1'b1, 4'b0010);
        cycle(1'b0, 1'b0, 1'b1, 4'b0100);
        cycle(1'b0, 1'b0, 1'b1, 4'b1000);
        cycle(1'b0, 1'b0, 1'b1, 4'b0001);
        chk("restart_not_yet", int'(locked_o), 0);
        cycle(1'b0, 1'b0, 1'b1, 4'b0010);
        chk("restart_locked", int'(locked_o), 1);

        // REV_W=2 instance wraps its counter after four revolutions but still pulses.
        cycle(1'b1, 1'b0, 1'b0, 4'b0);
        for (int s = 1; s <= 21; s++) begin
            qq = 4'b0001 << ((s - 1) % 4);
            cycle(1'b0, 1'b0, 1'b1, qq);
        end
        chk("rw2_rev",  int'(rev_cnt2_o), 0);
        chk("rw2_wrap", int'(wrap2_o),    1);
        chk("rw8_rev",  int'(rev_cnt_o),  4);

        // Randomized traffic: mostly legal rotation with glitches, gaps, clears and resets.
        cycle(1'b1, 1'b0, 1'b0, 4'b0);
        phase = 0;
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            c   = ($urandom_range(0, 59) == 0);
            v   = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 19);
            if (sel < 17)      qq = 4'b0001 << phase;
            else if (sel < 19) qq = 4'($urandom_range(0, 15));
            else               qq = 4'b0001 << $urandom_range(0, 3);
            cycle(r, c, v, qq);
            if (v && sel < 17) phase = (phase + 1) % 4;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
